// File: rtl/normalizer.sv
// normalizer: two-stage pipelined 32-bit normalizer behind a valid/ready stream.
//
// Stage 1 counts how far the word can be shifted left without losing
// information (leading zeros for unsigned, redundant sign bits for signed).
// Stage 2 applies that shift. Shifting o_data right by o_shift_amt (logical
// for unsigned, arithmetic for signed) gives back the original word.
//
// Handshake: a word moves across an interface on a rising edge where valid and
// ready are both high. Once valid is raised the producer holds its payload
// until accepted. Ready is combinational from downstream ready (no skid
// buffer); each stage advances when it is empty or its successor advances.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      input word valid
//   o_ready      block can accept a word this cycle
//   i_signed     1 = two's complement, 0 = unsigned
//   i_data       word to normalize
//   o_valid      result valid
//   i_ready      downstream accepts the result
//   o_data       normalized word
//   o_shift_amt  left-shift amount applied
//   o_zero       input was all-zero
//
// Build option: define NORMALIZER_CHECK_EN to compile in concurrent assertions
// (round trip, MSB property, stall stability, quiet output after reset).
module normalizer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [4:0]       o_shift_amt,
  output logic             o_zero
);

  logic             adv1, adv2, accept;
  logic             in_zero, run;
  logic [4:0]       lead_cnt;

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [4:0]       s1_cnt_q, s1_cnt_d;
  logic             s1_zero_q, s1_zero_d;

  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [4:0]       s2_amt_q, s2_amt_d;
  logic             s2_zero_q, s2_zero_d;

  assign adv2    = !s2_v_q || i_ready;
  assign adv1    = !s1_v_q || adv2;
  assign o_ready = adv1 && !i_rst;
  assign accept  = i_valid && o_ready;
  assign in_zero = (i_data == '0);

  // Shift count. Unsigned scans bits 31..1 for zeros, so the count tops out
  // at 31 and fits in 5 bits (the all-zero word is forced to 0 below).
  // Signed scans bits 30..0 for copies of the sign bit.
  always_comb begin
    lead_cnt = '0;
    run      = 1'b1;
    if (i_signed) begin
      for (int i = WIDTH - 2; i >= 0; i--) begin
        if (run && (i_data[i] == i_data[WIDTH-1])) lead_cnt = lead_cnt + 5'd1;
        else run = 1'b0;
      end
    end else begin
      for (int i = WIDTH - 1; i >= 1; i--) begin
        if (run && !i_data[i]) lead_cnt = lead_cnt + 5'd1;
        else run = 1'b0;
      end
    end
    if (in_zero) lead_cnt = '0;
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_cnt_d  = s1_cnt_q;
    s1_zero_d = s1_zero_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_amt_d  = s2_amt_q;
    s2_zero_d = s2_zero_q;

    if (adv1) s1_v_d = accept;
    if (accept) begin
      s1_data_d = i_data;
      s1_cnt_d  = lead_cnt;
      s1_zero_d = in_zero;
    end

    // Stage 2 payload only changes when a real word moves in, so the output
    // holds its last value while empty or stalled.
    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = s1_data_q << s1_cnt_q;
        s2_amt_d  = s1_cnt_q;
        s2_zero_d = s1_zero_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_cnt_q  <= '0;
      s1_zero_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_amt_q  <= '0;
      s2_zero_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_cnt_q  <= s1_cnt_d;
      s1_zero_q <= s1_zero_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_amt_q  <= s2_amt_d;
      s2_zero_q <= s2_zero_d;
    end
  end

  assign o_valid     = s2_v_q;
  assign o_data      = s2_data_q;
  assign o_shift_amt = s2_amt_q;
  assign o_zero      = s2_zero_q;

`ifdef NORMALIZER_CHECK_EN
  // The datapath itself never needs the mode or original word after stage 1;
  // the checker carries them alongside the pipeline.
  logic             s1_signed_q, s2_signed_q;
  logic [WIDTH-1:0] s2_orig_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_signed_q <= 1'b0;
      s2_signed_q <= 1'b0;
      s2_orig_q   <= '0;
    end else begin
      if (accept) s1_signed_q <= i_signed;
      if (adv2 && s1_v_q) begin
        s2_signed_q <= s1_signed_q;
        s2_orig_q   <= s1_data_q;
      end
    end
  end

  a_rt_unsigned: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && i_ready && !o_zero && !s2_signed_q) |-> ((o_data >> o_shift_amt) == s2_orig_q));
  a_rt_signed: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && i_ready && !o_zero && s2_signed_q) |->
      (($signed(o_data) >>> o_shift_amt) == $signed(s2_orig_q)));
  a_msb_unsigned: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !o_zero && !s2_signed_q) |-> o_data[WIDTH-1]);
  a_msb_signed: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !o_zero && s2_signed_q) |-> (o_data[WIDTH-1] ^ o_data[WIDTH-2]));
  a_stall_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_shift_amt) && $stable(o_zero)));
  a_reset_quiet: assert property (@(posedge i_clk) i_rst |=> !o_valid);
`endif

endmodule

// File: tb/tb_normalizer.sv
// tb_normalizer: randomized and directed checks of the normalizer against a
// behavioural model. The model picks the largest left shift k (0..31) whose
// matching right shift (logical or arithmetic) recovers the input word.
module tb_normalizer;

  typedef struct packed {
    logic        sgn;
    logic [31:0] din;
    logic        zero;
    logic [4:0]  amt;
    logic [31:0] dout;
  } exp_t;

  localparam int EW = $bits(exp_t);

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_signed = 1'b0;
  logic [31:0] i_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic [4:0]  o_shift_amt;
  logic        o_zero;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  normalizer #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_signed(i_signed), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_shift_amt(o_shift_amt), .o_zero(o_zero)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t ref_norm(input logic [31:0] d, input logic s);
    exp_t r;
    logic [31:0] sh, back;
    int best;
    r.sgn = s;
    r.din = d;
    if (d == 32'd0) begin
      r.zero = 1'b1;
      r.amt  = 5'd0;
      r.dout = 32'd0;
      return r;
    end
    best = 0;
    for (int k = 0; k < 32; k++) begin
      sh   = d << k;
      back = s ? 32'($signed(sh) >>> k) : (sh >> k);
      if (back == d) best = k;
    end
    r.zero = 1'b0;
    r.amt  = 5'(best);
    r.dout = d << best;
    return r;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0: w = $urandom >> $urandom_range(0, 31);
      1: w = ~($urandom >> $urandom_range(0, 31));
      2: w = $urandom;
      default: begin
        case ($urandom_range(0, 3))
          0: w = 32'h0000_0000;
          1: w = 32'hFFFF_FFFF;
          2: w = 32'h0000_0001;
          default: w = 32'h8000_0000;
        endcase
      end
    endcase
    return w;
  endfunction

  // ---------------- driver: one cycle ----------------
  // Drives inputs at the falling edge, then samples the settled outputs and
  // scores the transfers that will happen on the next rising edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] d,
                      input logic s, input logic rdy, output logic acc);
    logic        exp_rdy;
    exp_t        e;
    logic [31:0] back;
    @(negedge i_clk);
    i_rst    = rst;
    i_valid  = v;
    i_data   = d;
    i_signed = s;
    i_ready  = rdy;
    #1;
    // Two-entry buffer: accepts when not full, or when full but draining.
    exp_rdy = !rst && (rdy || (exp_q.size() < 2));
    chk("o_ready", 64'(o_ready), 64'(exp_rdy));
    acc = v && o_ready;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(o_valid), 64'd0);
      end else begin
        e = exp_t'(exp_q[0]);
        chk("o_data", 64'(o_data), 64'(e.dout));
        chk("o_shift_amt", 64'(o_shift_amt), 64'(e.amt));
        chk("o_zero", 64'(o_zero), 64'(e.zero));
        if (rdy && !rst) begin
          void'(exp_q.pop_front());
          if (!e.zero) begin
            back = e.sgn ? 32'($signed(o_data) >>> o_shift_amt) : (o_data >> o_shift_amt);
            chk("round_trip", 64'(back), 64'(e.din));
          end
        end
      end
    end
    if (acc) exp_q.push_back(EW'(ref_norm(d, s)));
    if (rst) exp_q.delete();
  endtask

  task automatic directed(input logic [31:0] d, input logic s, input logic [31:0] xd,
                          input logic [4:0] xa, input logic xz);
    logic acc;
    step(1'b0, 1'b1, d, s, 1'b1, acc);
    chk("dir_accept", 64'(acc), 64'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
    chk("dir_valid_n1", 64'(o_valid), 64'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
    chk("dir_valid_n2", 64'(o_valid), 64'd1);
    chk("dir_data", 64'(o_data), 64'(xd));
    chk("dir_amt", 64'(o_shift_amt), 64'(xa));
    chk("dir_zero", 64'(o_zero), 64'(xz));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        acc;
    logic [31:0] w[4];
    logic        ws[4];
    int          idx;
    logic        pend_v, pend_s;
    logic [31:0] pend_d;

    // Reset state
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_data", 64'(o_data), 64'd0);
    chk("rst_o_amt", 64'(o_shift_amt), 64'd0);
    chk("rst_o_zero", 64'(o_zero), 64'd0);
    chk("rst_o_ready", 64'(o_ready), 64'd0);

    // Directed cases with known answers
    directed(32'h0000_1000, 1'b0, 32'h8000_0000, 5'd19, 1'b0);
    directed(32'hFFFF_F000, 1'b1, 32'h8000_0000, 5'd19, 1'b0);
    directed(32'h0000_0005, 1'b1, 32'h5000_0000, 5'd28, 1'b0);
    directed(32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1);
    directed(32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1);
    directed(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b0);
    directed(32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0);
    directed(32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);

    // Back-to-back stream of 8 random words
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, rnd_word(), 1'($urandom_range(0, 1)), 1'b1, acc);
      chk("b2b_accept", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Stall: 4 words, downstream not ready for the first 4 cycles
    for (int i = 0; i < 4; i++) begin
      w[i]  = rnd_word();
      ws[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 4) step(1'b0, 1'b1, w[idx], ws[idx], (c >= 4), acc);
      else         step(1'b0, 1'b0, 32'd0, 1'b0, (c >= 4), acc);
      if (acc) idx++;
      if (idx == 4 && exp_q.size() == 0) break;
    end
    chk("stall_all_sent", 64'(idx), 64'd4);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two words in flight
    step(1'b0, 1'b1, rnd_word(), 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, rnd_word(), 1'b1, 1'b0, acc);
    step(1'b1, 1'b1, rnd_word(), 1'b0, 1'b0, acc);
    chk("rst_mid_accept", 64'(acc), 64'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
    chk("post_rst_valid", 64'(o_valid), 64'd0);
    chk("post_rst_ready", 64'(o_ready), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);

    // Random traffic with random backpressure; a word is held until accepted
    pend_v = 1'b0;
    pend_d = '0;
    pend_s = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v = 1'b1;
        pend_d = rnd_word();
        pend_s = 1'($urandom_range(0, 1));
      end
      step(1'b0, pend_v, pend_d, pend_s, ($urandom_range(0, 2) != 0), acc);
      if (acc) pend_v = 1'b0;
    end

    // Drain with a bounded wait
    for (int c = 0; c < 20 && exp_q.size() != 0; c++)
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
